// File: rtl/dsp_run_sequencer.sv
// Boot/run sequencer for the dsp core: streams program and data words into the memories,
// pulses the core reset, then runs until halt or cycle budget. Option macro: LOAD_CHECKSUM_EN (adds ld_sum).
module dsp_run_sequencer #(
    parameter int IWIDTH     = 16,
    parameter int DWIDTH     = 16,
    parameter int IADDR_W    = 12,
    parameter int DADDR_W    = 8,
    parameter int RST_CYCLES = 2,
    parameter int MAX_CYCLES = 4122,
    parameter int HALT_WIN   = 4,
    localparam int LW = (IWIDTH > DWIDTH) ? IWIDTH : DWIDTH
) (
    input  logic               clk,
    input  logic               reset,
`ifdef LOAD_CHECKSUM_EN
    output logic [15:0]        ld_sum,
`endif
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic               ld_sel,
    input  logic               ld_last,
    input  logic [LW-1:0]      ld_data,
    input  logic               start,
    input  logic               abort,
    output logic               imem_we,
    output logic [IADDR_W-1:0] imem_addr,
    output logic [IWIDTH-1:0]  imem_wdata,
    output logic               dmem_we,
    output logic [DADDR_W-1:0] dmem_addr,
    output logic [DWIDTH-1:0]  dmem_wdata,
    input  logic [IADDR_W-1:0] cpu_pc,
    output logic               cpu_reset,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic               load_err,
    output logic [31:0]        cycle_cnt
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int SW  = $clog2(HALT_WIN + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RST, S_RUN, S_DONE} state_t;

    state_t             state;
    state_t             ns;
    // One extra bit per counter: the MSB set means every address has been written.
    logic [IADDR_W:0]   icnt;
    logic [DADDR_W:0]   dcnt;
    logic [RCW-1:0]     rst_cnt;
    logic [SW-1:0]      stable;
    logic [SW-1:0]      stable_nx;
    logic [IADDR_W-1:0] prev_pc;
    logic               pc_valid;
    logic               pc_eq;
    logic               accept;
    logic               start_ok;
    logic               halt_hit;
    logic               budget_hit;
    logic [31:0]        cnt_inc;

    assign accept     = ld_ready && ld_valid && !abort;
    assign start_ok   = start && !abort && (state == S_IDLE || state == S_DONE);
    assign pc_eq      = pc_valid && (cpu_pc == prev_pc);
    assign stable_nx  = pc_eq ? stable + SW'(1) : '0;
    assign halt_hit   = stable_nx >= SW'(HALT_WIN);
    assign cnt_inc    = cycle_cnt + 32'd1;
    assign budget_hit = cnt_inc >= 32'(MAX_CYCLES);

    always_comb begin
        ns = state;
        unique case (state)
            S_IDLE: if (start) ns = S_LOAD;
            S_LOAD: if (accept && ld_last) ns = S_RST;
            S_RST:  if (rst_cnt == RCW'(RST_CYCLES - 1)) ns = S_RUN;
            S_RUN:  if (halt_hit || budget_hit) ns = S_DONE;
            S_DONE: if (start) ns = S_LOAD;
            default: ns = S_IDLE;
        endcase
        if (abort) ns = S_IDLE;
    end

    // Handshake/status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            ld_ready   <= 1'b0;
            busy       <= 1'b0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            timeout    <= 1'b0;
            load_err   <= 1'b0;
            cycle_cnt  <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            icnt       <= '0;
            dcnt       <= '0;
            rst_cnt    <= '0;
            stable     <= '0;
            prev_pc    <= '0;
            pc_valid   <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            ld_sum     <= '0;
`endif
        end else begin
            state     <= ns;
            ld_ready  <= (ns == S_LOAD);
            busy      <= (ns == S_LOAD) || (ns == S_RST) || (ns == S_RUN);
            cpu_reset <= (ns != S_RUN);
            imem_we   <= 1'b0;
            dmem_we   <= 1'b0;
            prev_pc   <= cpu_pc;
            pc_valid  <= (state == S_RUN) && (ns == S_RUN);
            rst_cnt   <= (state == S_RST && ns == S_RST) ? rst_cnt + RCW'(1) : '0;

            if (start_ok) begin
                icnt      <= '0;
                dcnt      <= '0;
                done      <= 1'b0;
                timeout   <= 1'b0;
                load_err  <= 1'b0;
                cycle_cnt <= '0;
            end
            if (abort) begin
                done    <= 1'b0;
                timeout <= 1'b0;
            end

            // A beat to a full target is swallowed and only flags the overflow.
            if (accept) begin
                if (!ld_sel) begin
                    if (icnt[IADDR_W]) begin
                        load_err <= 1'b1;
                    end else begin
                        imem_we    <= 1'b1;
                        imem_addr  <= icnt[IADDR_W-1:0];
                        imem_wdata <= ld_data[IWIDTH-1:0];
                        icnt       <= icnt + 1'b1;
                    end
                end else begin
                    if (dcnt[DADDR_W]) begin
                        load_err <= 1'b1;
                    end else begin
                        dmem_we    <= 1'b1;
                        dmem_addr  <= dcnt[DADDR_W-1:0];
                        dmem_wdata <= ld_data[DWIDTH-1:0];
                        dcnt       <= dcnt + 1'b1;
                    end
                end
            end

            // Halt detection takes priority over the budget when both land together.
            if (state == S_RUN && !abort) begin
                cycle_cnt <= cnt_inc;
                stable    <= stable_nx;
                if (halt_hit)
                    done <= 1'b1;
                else if (budget_hit)
                    timeout <= 1'b1;
            end else begin
                stable <= '0;
            end

`ifdef LOAD_CHECKSUM_EN
            if (abort || start_ok)
                ld_sum <= '0;
            else if (accept)
                ld_sum <= ld_sum + 16'(ld_data);
`endif
        end
    end

endmodule

// File: tb/tb_dsp_run_sequencer.sv
// Self-checking bench for dsp_run_sequencer: vector table for load/run handshakes, hand
// sequences for overflow/abort/reset, and randomized loads and PC streams against a model.
module tb_dsp_run_sequencer;

    localparam int IAW    = 4;
    localparam int DAW    = 2;
    localparam int RSTC   = 2;
    localparam int MAXC   = 40;
    localparam int HW     = 4;
    localparam int IDEPTH = 1 << IAW;
    localparam int DDEPTH = 1 << DAW;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ld_valid = 1'b0, ld_sel = 1'b0, ld_last = 1'b0;
    logic [15:0] ld_data = '0;
    logic start = 1'b0, abort = 1'b0;
    logic [IAW-1:0] cpu_pc = '0;
    logic ld_ready, imem_we, dmem_we, cpu_reset, busy, done, timeout, load_err;
    logic [IAW-1:0] imem_addr;
    logic [15:0] imem_wdata, dmem_wdata;
    logic [DAW-1:0] dmem_addr;
    logic [31:0] cycle_cnt;
`ifdef LOAD_CHECKSUM_EN
    logic [15:0] ld_sum;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dsp_run_sequencer #(
        .IWIDTH(16), .DWIDTH(16), .IADDR_W(IAW), .DADDR_W(DAW),
        .RST_CYCLES(RSTC), .MAX_CYCLES(MAXC), .HALT_WIN(HW)
    ) dut (
        .clk(clk), .reset(reset),
`ifdef LOAD_CHECKSUM_EN
        .ld_sum(ld_sum),
`endif
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_last(ld_last),
        .ld_data(ld_data), .start(start), .abort(abort),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .cpu_pc(cpu_pc), .cpu_reset(cpu_reset), .busy(busy), .done(done),
        .timeout(timeout), .load_err(load_err), .cycle_cnt(cycle_cnt)
    );

    // Snoop the memory write ports to rebuild what the core would see.
    logic [15:0] obs_imem [IDEPTH];
    logic [15:0] obs_dmem [DDEPTH];
    int obs_iw = 0;
    int obs_dw = 0;

    always @(posedge clk) begin
        if (imem_we) begin
            obs_imem[imem_addr] <= imem_wdata;
            obs_iw <= obs_iw + 1;
        end
        if (dmem_we) begin
            obs_dmem[dmem_addr] <= dmem_wdata;
            obs_dw <= obs_dw + 1;
        end
    end

    typedef struct {
        logic        st, ab, v, s, l;
        logic [15:0] d;
        logic [3:0]  pc;
        logic        e_ready, e_busy, e_crst, e_iwe;
        logic [3:0]  e_ia;
        logic [15:0] e_id;
        logic        e_dwe;
        logic [1:0]  e_da;
        logic [15:0] e_dd;
    } vec_t;

    vec_t vecs[$];
    bit sel_q[$];
    logic [15:0] data_q[$];

    function automatic vec_t mk(input logic st, ab, v, s, l, input logic [15:0] d,
                                input logic [3:0] pc, input logic er, eb, ec, eiw,
                                input logic [3:0] eia, input logic [15:0] eid,
                                input logic edw, input logic [1:0] eda, input logic [15:0] edd);
        vec_t r;
        r.st = st; r.ab = ab; r.v = v; r.s = s; r.l = l; r.d = d; r.pc = pc;
        r.e_ready = er; r.e_busy = eb; r.e_crst = ec; r.e_iwe = eiw; r.e_ia = eia;
        r.e_id = eid; r.e_dwe = edw; r.e_da = eda; r.e_dd = edd;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic noteFail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    task automatic applyStimulus(input vec_t v);
        start = v.st; abort = v.ab; ld_valid = v.v; ld_sel = v.s; ld_last = v.l;
        ld_data = v.d; cpu_pc = v.pc;
    endtask

    // Start a load of sel_q/data_q, then compare the written images against a per-target tally.
    task automatic loadSeq(input bit gaps);
        int iw0 = obs_iw;
        int dw0 = obs_dw;
        int ni = 0;
        int nd = 0;
        logic [15:0] ei[$];
        logic [15:0] ed[$];
        logic [15:0] sum = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("ld_start_ready", 32'(ld_ready), 1);
        checkOutput("ld_start_done_clr", 32'(done), 0);
        checkOutput("ld_start_tmo_clr", 32'(timeout), 0);
        checkOutput("ld_start_err_clr", 32'(load_err), 0);
        checkOutput("ld_start_cnt_clr", cycle_cnt, 0);
        for (int b = 0; b < sel_q.size(); b++) begin
            if (gaps)
                for (int g = 0; g < 3 && $urandom_range(0, 3) == 0; g++) step();
            ld_valid = 1'b1;
            ld_sel   = sel_q[b];
            ld_data  = data_q[b];
            ld_last  = (b == sel_q.size() - 1);
            step();
            ld_valid = 1'b0;
            ld_last  = 1'b0;
            sum += data_q[b];
            if (!sel_q[b]) begin
                ni++;
                if (ei.size() < IDEPTH) ei.push_back(data_q[b]);
            end else begin
                nd++;
                if (ed.size() < DDEPTH) ed.push_back(data_q[b]);
            end
        end
        step();
        checkOutput("ld_end_ready", 32'(ld_ready), 0);
        checkOutput("ld_end_busy", 32'(busy), 1);
        checkOutput("ld_imem_writes", 32'(obs_iw - iw0), 32'(ei.size()));
        checkOutput("ld_dmem_writes", 32'(obs_dw - dw0), 32'(ed.size()));
        checkOutput("ld_err", 32'(load_err), 32'((ni > IDEPTH) || (nd > DDEPTH)));
        foreach (ei[k]) checkOutput($sformatf("imem[%0d]", k), 32'(obs_imem[k]), 32'(ei[k]));
        foreach (ed[k]) checkOutput($sformatf("dmem[%0d]", k), 32'(obs_dmem[k]), 32'(ed[k]));
`ifdef LOAD_CHECKSUM_EN
        checkOutput("ld_sum", 32'(ld_sum), 32'(sum));
`endif
    endtask

    // Drive a PC stream through RUN; the model declares a halt at the first index whose
    // trailing HW+1 samples are all equal, otherwise a timeout on the MAXC-th cycle.
    task automatic runPc(input int kind, output int end_cnt);
        logic [IAW-1:0] p [MAXC+8];
        int exp_idx = -1;
        bit exp_halt = 1'b0;
        int guard = 0;
        int i;
        bit ended = 1'b0;
        end_cnt = -1;
        for (int k = 0; k < MAXC + 8; k++) begin
            case (kind)
                0: p[k] = (k < 10) ? IAW'(k) : IAW'(9);
                1: p[k] = IAW'(k);
                2: p[k] = IAW'($urandom_range(0, 2));
                default: p[k] = (k > 0 && $urandom_range(0, 3) != 0) ? p[k-1] : IAW'($urandom_range(0, 15));
            endcase
        end
        for (int k = 0; k < MAXC && exp_idx < 0; k++) begin
            bit win = (k >= HW);
            for (int j = 1; j <= HW && win; j++)
                if (p[k-j] != p[k]) win = 1'b0;
            if (win) begin
                exp_idx = k;
                exp_halt = 1'b1;
            end else if (k + 1 == MAXC) begin
                exp_idx = k;
            end
        end
        while (cpu_reset && guard < 10) begin
            step();
            guard++;
        end
        if (cpu_reset) begin
            noteFail("run_entry");
            return;
        end
        for (i = 0; i < MAXC + 4; i++) begin
            cpu_pc = p[i];
            step();
            if (done || timeout) begin
                ended = 1'b1;
                break;
            end
        end
        if (!ended) begin
            noteFail("run_end");
            return;
        end
        end_cnt = int'(cycle_cnt);
        checkOutput("run_end_idx", 32'(i), 32'(exp_idx));
        checkOutput("run_done", 32'(done), 32'(exp_halt));
        checkOutput("run_timeout", 32'(timeout), 32'(!exp_halt));
        checkOutput("run_cycle_cnt", cycle_cnt, 32'(exp_idx + 1));
        checkOutput("run_cpu_reset", 32'(cpu_reset), 1);
        checkOutput("run_busy", 32'(busy), 0);
        for (int h = 0; h < 3; h++) begin
            cpu_pc = cpu_pc + 1'b1;
            step();
        end
        checkOutput("done_cnt_hold", cycle_cnt, 32'(exp_idx + 1));
        checkOutput("done_flag_hold", 32'(done), 32'(exp_halt));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cnt;
        int w0;

        // Reset held low for two cycles.
        step();
        step();
        checkOutput("rst_cpu_reset", 32'(cpu_reset), 1);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_ready", 32'(ld_ready), 0);
        checkOutput("rst_imem_we", 32'(imem_we), 0);
        checkOutput("rst_cycle_cnt", cycle_cnt, 0);
        reset = 1'b1;
        step();

        //            st ab v  s  l  data      pc | rdy bsy crst iwe ia id        dwe da dd
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0,   1, 1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h7F89, 0,   1, 1, 1, 1, 0, 16'h7F89, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h7E05, 0,   1, 1, 1, 1, 1, 16'h7E05, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 0, 1, 16'hF900, 0,   0, 1, 1, 1, 2, 16'hF900, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0,   0, 1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0,   0, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 1,   0, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 2,   0, 1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 2,   0, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 1, 0, 0, 0, 16'h0000, 0,   0, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000));
        vecs.push_back(mk(1, 0, 0, 0, 0, 16'h0000, 0,   1, 1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h1111, 0,   1, 1, 1, 1, 0, 16'h1111, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 1, 0, 16'h2222, 0,   1, 1, 1, 0, 0, 16'h0000, 1, 0, 16'h2222));
        vecs.push_back(mk(0, 0, 0, 0, 0, 16'h0000, 0,   1, 1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 0, 0, 16'h3333, 0,   1, 1, 1, 1, 1, 16'h3333, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 0, 1, 1, 1, 16'h4444, 0,   0, 1, 1, 0, 0, 16'h0000, 1, 1, 16'h4444));
        vecs.push_back(mk(1, 0, 1, 0, 0, 16'h5555, 0,   0, 1, 1, 0, 0, 16'h0000, 0, 0, 16'h0000));
        vecs.push_back(mk(0, 1, 0, 0, 0, 16'h0000, 0,   0, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("row%0d_ready", i), 32'(ld_ready), 32'(vecs[i].e_ready));
            checkOutput($sformatf("row%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            checkOutput($sformatf("row%0d_cpu_reset", i), 32'(cpu_reset), 32'(vecs[i].e_crst));
            checkOutput($sformatf("row%0d_imem_we", i), 32'(imem_we), 32'(vecs[i].e_iwe));
            checkOutput($sformatf("row%0d_dmem_we", i), 32'(dmem_we), 32'(vecs[i].e_dwe));
            checkOutput($sformatf("row%0d_done", i), 32'(done), 0);
            if (vecs[i].e_iwe) begin
                checkOutput($sformatf("row%0d_imem_addr", i), 32'(imem_addr), 32'(vecs[i].e_ia));
                checkOutput($sformatf("row%0d_imem_wdata", i), 32'(imem_wdata), 32'(vecs[i].e_id));
            end
            if (vecs[i].e_dwe) begin
                checkOutput($sformatf("row%0d_dmem_addr", i), 32'(dmem_addr), 32'(vecs[i].e_da));
                checkOutput($sformatf("row%0d_dmem_wdata", i), 32'(dmem_wdata), 32'(vecs[i].e_dd));
            end
        end
        applyStimulus(mk(0, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000));
        step();

        // PC counts 0..9 then parks at 9: halt on the 4th stable compare, cycle 14.
        sel_q = '{0, 0, 0};
        data_q = '{16'(($urandom)), 16'(($urandom)), 16'(($urandom))};
        loadSeq(1'b0);
        runPc(0, cnt);
        checkOutput("halt_cycle_cnt", 32'(cnt), 14);

        // PC never repeats: budget expires exactly at MAXC.
        sel_q = '{1, 0};
        data_q = '{16'h0BAD, 16'h0C0D};
        loadSeq(1'b0);
        runPc(1, cnt);
        checkOutput("timeout_cycle_cnt", 32'(cnt), MAXC);

        // Five data beats into a four-word memory, then abort while running.
        sel_q = '{1, 1, 1, 1, 1};
        data_q = '{16'hD000, 16'hD001, 16'hD002, 16'hD003, 16'hD004};
        w0 = obs_dw;
        loadSeq(1'b0);
        checkOutput("ovf_writes", 32'(obs_dw - w0), 4);
        checkOutput("ovf_err", 32'(load_err), 1);
        for (int g = 0; g < 10 && cpu_reset; g++) step();
        cpu_pc = 4'd3;
        step();
        cpu_pc = 4'd7;
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_cpu_reset", 32'(cpu_reset), 1);
        checkOutput("abort_done", 32'(done), 0);
        checkOutput("abort_err_hold", 32'(load_err), 1);

        // Checksum wrap: 0xFFFF + 0x0002 = 0x0001.
        sel_q = '{1, 1};
        data_q = '{16'hFFFF, 16'h0002};
        loadSeq(1'b0);
`ifdef LOAD_CHECKSUM_EN
        checkOutput("sum_wrap", 32'(ld_sum), 32'h0001);
`endif
        abort = 1'b1;
        step();
        abort = 1'b0;
`ifdef LOAD_CHECKSUM_EN
        checkOutput("sum_abort_clr", 32'(ld_sum), 0);
`endif

        // Reset in the middle of a load kills any further write.
        w0 = obs_iw;
        start = 1'b1;
        step();
        start = 1'b0;
        ld_valid = 1'b1;
        ld_sel = 1'b0;
        ld_data = 16'hABCD;
        step();
        checkOutput("rml_first_we", 32'(imem_we), 1);
        ld_data = 16'h1234;
        reset = 1'b0;
        step();
        checkOutput("rml_we_cut", 32'(imem_we), 0);
        checkOutput("rml_ready", 32'(ld_ready), 0);
        checkOutput("rml_busy", 32'(busy), 0);
        checkOutput("rml_cpu_reset", 32'(cpu_reset), 1);
        reset = 1'b1;
        step();
        step();
        ld_valid = 1'b0;
        step();
        checkOutput("rml_writes", 32'(obs_iw - w0), 1);

        // Randomized loads and PC streams.
        for (int it = 0; it < 8; it++) begin
            int n = $urandom_range(1, 12);
            sel_q = {};
            data_q = {};
            for (int b = 0; b < n; b++) begin
                sel_q.push_back(1'($urandom_range(0, 1)));
                data_q.push_back(16'($urandom));
            end
            loadSeq(1'b1);
            runPc(2 + (it % 2), cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
